// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer: serialises TLBP/TLBR/TLBWI/TLBWR towards
// CP0 and the TLB, requests a refetch after state-changing ops, owns Random.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [1:0]      op_type,
  input  logic [31:0]     op_pc,
  output logic            op_ready,
  input  logic            cancel,
  output logic            done,
  output logic            refetch,
  output logic [31:0]     refetch_pc,
  input  logic [18:0]     cp0_vpn2,
  input  logic [7:0]      cp0_asid,
  input  logic [IDXW-1:0] cp0_index,
  input  logic [IDXW-1:0] wired,
  input  logic            wired_we,
  output logic [IDXW-1:0] random,
  output logic [18:0]     s_vpn2,
  output logic [7:0]      s_asid,
  input  logic            s_found,
  input  logic [IDXW-1:0] s_index,
  output logic            tlbp_we,
  output logic            tlbp_found,
  output logic [IDXW-1:0] tlbp_index,
  output logic [IDXW-1:0] r_index,
  output logic            tlbr_we,
  output logic            tlb_we,
  output logic [IDXW-1:0] w_index
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    COMMIT,
    FLUSH
  } state_t;

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b11;
  localparam logic [IDXW-1:0] RMAX = IDXW'(TLBNUM - 1);

  state_t          state, state_d;
  logic [1:0]      type_q;
  logic [31:0]     pc_q;
  logic [18:0]     vpn2_q;
  logic [7:0]      asid_q;
  logic [IDXW-1:0] idx_q;
  logic            found_q;
  logic [IDXW-1:0] sidx_q;
  logic [IDXW-1:0] random_q;
  logic            accept;
  logic            is_p;
  logic            is_r;
  logic            is_w;

  assign accept = op_valid & op_ready;
  assign is_p   = (type_q == OP_TLBP);
  assign is_r   = (type_q == OP_TLBR);
  assign is_w   = type_q[1];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    op_ready = 1'b0;
    done     = 1'b0;
    refetch  = 1'b0;
    tlbp_we  = 1'b0;
    tlbr_we  = 1'b0;
    tlb_we   = 1'b0;
    unique case (state)
      IDLE: begin
        op_ready = ~cancel & ~reset;
        if (op_valid & ~cancel & ~reset)
          state_d = (op_type == OP_TLBP) ? SEARCH : COMMIT;
      end
      SEARCH: begin
        state_d = cancel ? IDLE : COMMIT;
      end
      COMMIT: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          unique case (1'b1)
            is_p: begin
              tlbp_we = 1'b1;
              done    = 1'b1;
              state_d = IDLE;
            end
            is_r: begin
              tlbr_we = 1'b1;
              state_d = FLUSH;
            end
            is_w: begin
              tlb_we  = 1'b1;
              state_d = FLUSH;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      FLUSH: begin
        refetch = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset wins over everything, including an in-flight commit.
    if (reset) begin
      state_d = IDLE;
      done    = 1'b0;
      refetch = 1'b0;
      tlbp_we = 1'b0;
      tlbr_we = 1'b0;
      tlb_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      type_q  <= 2'b00;
      pc_q    <= 32'h0;
      vpn2_q  <= 19'h0;
      asid_q  <= 8'h0;
      idx_q   <= '0;
      found_q <= 1'b0;
      sidx_q  <= '0;
    end else begin
      if (accept) begin
        type_q <= op_type;
        pc_q   <= op_pc;
        vpn2_q <= cp0_vpn2;
        asid_q <= cp0_asid;
        idx_q  <= (op_type == OP_TLBWR) ? random_q : cp0_index;
      end
      if (state == SEARCH) begin
        found_q <= s_found;
        sidx_q  <= s_index;
      end
    end
  end

  // Random sweeps down from the top and wraps once it reaches Wired.
  always_ff @(posedge clk) begin
    if (reset)                 random_q <= RMAX;
    else if (wired_we)         random_q <= RMAX;
    else if (random_q <= wired) random_q <= RMAX;
    else                       random_q <= random_q - 1'b1;
  end

  assign random     = random_q;
  assign s_vpn2     = vpn2_q;
  assign s_asid     = asid_q;
  assign tlbp_found = found_q & tlbp_we;
  assign tlbp_index = sidx_q;
  assign r_index    = idx_q;
  assign w_index    = idx_q;
  assign refetch_pc = pc_q + 32'd4;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed vector bench for tlb_op_ctrl with a one-entry TLB search model.
module tb_tlb_op_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [1:0]  op_type;
  logic [31:0] op_pc;
  logic        op_ready;
  logic        cancel;
  logic        done;
  logic        refetch;
  logic [31:0] refetch_pc;
  logic [18:0] cp0_vpn2;
  logic [7:0]  cp0_asid;
  logic [3:0]  cp0_index;
  logic [3:0]  wired;
  logic        wired_we;
  logic [3:0]  random;
  logic [18:0] s_vpn2;
  logic [7:0]  s_asid;
  logic        s_found;
  logic [3:0]  s_index;
  logic        tlbp_we;
  logic        tlbp_found;
  logic [3:0]  tlbp_index;
  logic [3:0]  r_index;
  logic        tlbr_we;
  logic        tlb_we;
  logic [3:0]  w_index;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlb_op_ctrl #(.TLBNUM(16), .IDXW(4)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_type(op_type), .op_pc(op_pc),
    .op_ready(op_ready), .cancel(cancel), .done(done),
    .refetch(refetch), .refetch_pc(refetch_pc),
    .cp0_vpn2(cp0_vpn2), .cp0_asid(cp0_asid), .cp0_index(cp0_index),
    .wired(wired), .wired_we(wired_we), .random(random),
    .s_vpn2(s_vpn2), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index),
    .tlbp_we(tlbp_we), .tlbp_found(tlbp_found), .tlbp_index(tlbp_index),
    .r_index(r_index), .tlbr_we(tlbr_we),
    .tlb_we(tlb_we), .w_index(w_index)
  );

  // TLB entry 7 holds vpn2 0x12345 / asid 0x05; everything else misses.
  always_comb begin
    s_found = (s_vpn2 == 19'h12345) && (s_asid == 8'h05);
    s_index = s_found ? 4'd7 : 4'd0;
  end

  localparam logic [6:0] R  = 7'b1000000;
  localparam logic [6:0] D  = 7'b0100000;
  localparam logic [6:0] F  = 7'b0010000;
  localparam logic [6:0] P  = 7'b0001000;
  localparam logic [6:0] H  = 7'b0000100;
  localparam logic [6:0] RD = 7'b0000010;
  localparam logic [6:0] W  = 7'b0000001;

  typedef struct {
    logic        rst;
    logic        v;
    logic [1:0]  typ;
    logic [31:0] pc;
    logic        cxl;
    logic [18:0] vpn;
    logic [7:0]  asid;
    logic [3:0]  cidx;
    logic [6:0]  exp;
    logic [3:0]  eidx;
    logic [31:0] epc;
    logic        crnd;
    logic [3:0]  ernd;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(logic rst, logic v, logic [1:0] typ,
                              logic [31:0] pc, logic cxl, logic [18:0] vpn,
                              logic [7:0] asid, logic [3:0] cidx,
                              logic [6:0] exp, logic [3:0] eidx,
                              logic [31:0] epc, logic crnd, logic [3:0] ernd);
    vec_t t;
    t.rst = rst; t.v = v; t.typ = typ; t.pc = pc; t.cxl = cxl;
    t.vpn = vpn; t.asid = asid; t.cidx = cidx; t.exp = exp;
    t.eidx = eidx; t.epc = epc; t.crnd = crnd; t.ernd = ernd;
    return t;
  endfunction

  function automatic logic [6:0] act();
    return {op_ready, done, refetch, tlbp_we, tlbp_found, tlbr_we, tlb_we};
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_type = 2'b00; op_pc = 32'h0;
    cancel = 1'b0; cp0_vpn2 = 19'h0; cp0_asid = 8'h0; cp0_index = 4'h0;
    wired = 4'h0; wired_we = 1'b0;

    //           rst v typ pc            cxl vpn       asid   cidx exp        eidx epc           crnd ernd
    vecs[0]  = mk(1, 1, 2'd0, 32'h0,        0, 19'h0,     8'h0,  4'd0, 7'h0,     4'd0, 32'h0,        0, 4'd0);
    vecs[1]  = mk(1, 0, 2'd0, 32'h0,        0, 19'h0,     8'h0,  4'd0, 7'h0,     4'd0, 32'h0,        1, 4'd15);
    vecs[2]  = mk(0, 0, 2'd0, 32'h0,        0, 19'h0,     8'h0,  4'd0, R,        4'd0, 32'h0,        1, 4'd15);
    vecs[3]  = mk(0, 1, 2'd0, 32'h1000,     0, 19'h12345, 8'h05, 4'd0, R,        4'd0, 32'h0,        0, 4'd0);
    vecs[4]  = mk(0, 0, 2'd0, 32'h0,        0, 19'h0,     8'h0,  4'd0, 7'h0,     4'd0, 32'h0,        0, 4'd0);
    vecs[5]  = mk(0, 0, 2'd0, 32'h0,        0, 19'h0,     8'h0,  4'd0, D|P|H,    4'd7, 32'h0,        0, 4'd0);
    vecs[6]  = mk(0, 1, 2'd0, 32'h1004,     0, 19'h00001, 8'h05, 4'd0, R,        4'd0, 32'h0,        0, 4'd0);
    vecs[7]  = mk(0, 0, 2'd0, 32'h0,        0, 19'h12345, 8'h05, 4'd0, 7'h0,     4'd0, 32'h0,        0, 4'd0);
    vecs[8]  = mk(0, 0, 2'd0, 32'h0,        0, 19'h0,     8'h0,  4'd0, D|P,      4'd0, 32'h0,        0, 4'd0);
    vecs[9]  = mk(0, 1, 2'd2, 32'hBFC00100, 0, 19'h0,     8'h0,  4'd3, R,        4'd0, 32'h0,        0, 4'd0);
    vecs[10] = mk(0, 0, 2'd0, 32'h0,        0, 19'h0,     8'h0,  4'd9, W,        4'd3, 32'h0,        0, 4'd0);
    vecs[11] = mk(0, 0, 2'd0, 32'h0,        0, 19'h0,     8'h0,  4'd0, D|F,      4'd0, 32'hBFC00104, 0, 4'd0);
    vecs[12] = mk(0, 1, 2'd1, 32'hFFFFFFFC, 0, 19'h0,     8'h0,  4'd2, R,        4'd0, 32'h0,        0, 4'd0);
    vecs[13] = mk(0, 0, 2'd0, 32'h0,        0, 19'h0,     8'h0,  4'd0, RD,       4'd2, 32'h0,        0, 4'd0);
    vecs[14] = mk(0, 0, 2'd0, 32'h0,        0, 19'h0,     8'h0,  4'd0, D|F,      4'd0, 32'h0,        0, 4'd0);
    vecs[15] = mk(0, 1, 2'd0, 32'h2000,     0, 19'h12345, 8'h05, 4'd0, R,        4'd0, 32'h0,        0, 4'd0);
    vecs[16] = mk(0, 0, 2'd0, 32'h0,        1, 19'h0,     8'h0,  4'd0, 7'h0,     4'd0, 32'h0,        0, 4'd0);
    vecs[17] = mk(0, 0, 2'd0, 32'h0,        0, 19'h0,     8'h0,  4'd0, R,        4'd0, 32'h0,        0, 4'd0);
    vecs[18] = mk(0, 1, 2'd2, 32'h100,      0, 19'h0,     8'h0,  4'd5, R,        4'd0, 32'h0,        0, 4'd0);
    vecs[19] = mk(0, 0, 2'd0, 32'h0,        1, 19'h0,     8'h0,  4'd0, 7'h0,     4'd0, 32'h0,        0, 4'd0);
    vecs[20] = mk(0, 1, 2'd2, 32'h200,      0, 19'h0,     8'h0,  4'd6, R,        4'd0, 32'h0,        0, 4'd0);
    vecs[21] = mk(0, 0, 2'd0, 32'h0,        0, 19'h0,     8'h0,  4'd0, W,        4'd6, 32'h0,        0, 4'd0);
    vecs[22] = mk(0, 0, 2'd0, 32'h0,        1, 19'h0,     8'h0,  4'd0, D|F,      4'd0, 32'h204,      0, 4'd0);
    vecs[23] = mk(0, 1, 2'd2, 32'h0,        1, 19'h0,     8'h0,  4'd1, 7'h0,     4'd0, 32'h0,        0, 4'd0);
    vecs[24] = mk(0, 0, 2'd0, 32'h0,        0, 19'h0,     8'h0,  4'd0, R,        4'd0, 32'h0,        0, 4'd0);
    vecs[25] = mk(0, 1, 2'd2, 32'h300,      0, 19'h0,     8'h0,  4'd4, R,        4'd0, 32'h0,        0, 4'd0);
    vecs[26] = mk(1, 0, 2'd0, 32'h0,        0, 19'h0,     8'h0,  4'd0, 7'h0,     4'd0, 32'h0,        0, 4'd0);
    vecs[27] = mk(0, 0, 2'd0, 32'h0,        0, 19'h0,     8'h0,  4'd0, R,        4'd0, 32'h0,        1, 4'd15);

    for (int i = 0; i < 28; i++) begin
      @(posedge clk);
      #1;
      reset = vecs[i].rst; op_valid = vecs[i].v; op_type = vecs[i].typ;
      op_pc = vecs[i].pc; cancel = vecs[i].cxl; cp0_vpn2 = vecs[i].vpn;
      cp0_asid = vecs[i].asid; cp0_index = vecs[i].cidx;
      #1;
      chk($sformatf("v%0d flags", i), 32'(act()), 32'(vecs[i].exp));
      if (vecs[i].exp[3])
        chk($sformatf("v%0d tlbp_index", i), 32'(tlbp_index), 32'(vecs[i].eidx));
      if (vecs[i].exp[1])
        chk($sformatf("v%0d r_index", i), 32'(r_index), 32'(vecs[i].eidx));
      if (vecs[i].exp[0])
        chk($sformatf("v%0d w_index", i), 32'(w_index), 32'(vecs[i].eidx));
      if (vecs[i].exp[4])
        chk($sformatf("v%0d refetch_pc", i), refetch_pc, vecs[i].epc);
      if (vecs[i].crnd)
        chk($sformatf("v%0d random", i), 32'(random), 32'(vecs[i].ernd));
    end

    // Random sweep with wired=4, then TLBWR and a Wired write.
    @(posedge clk);
    #1;
    op_valid = 1'b0; cancel = 1'b0; wired = 4'd4; reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("rnd seq %0d", i), 32'(random), (i < 12) ? 32'(15 - i) : 32'd15);
      tick();
    end
    for (int i = 0; i < 5; i++) tick();
    chk("rnd before tlbwr", 32'(random), 32'd9);
    op_valid = 1'b1; op_type = 2'b11; op_pc = 32'h400; cp0_index = 4'd1;
    tick();
    op_valid = 1'b0;
    chk("tlbwr tlb_we", 32'(tlb_we), 32'd1);
    chk("tlbwr w_index", 32'(w_index), 32'd9);
    tick();
    chk("tlbwr refetch", 32'({refetch, done}), 32'b11);
    chk("rnd before wired_we", 32'(random), 32'd7);
    wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    chk("rnd after wired_we", 32'(random), 32'd15);

    // Wired at the top pins Random.
    wired = 4'd15;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rnd pinned %0d", i), 32'(random), 32'd15);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
